// File: rtl/mcp_reg_decoder.sv
// -----------------------------------------------------------------------------
// mcp_reg_decoder
//
// Decodes MCP23S17-style SPI frames (opcode, register address, data...) from
// the SPI slave byte stream. Data lands in a register bank laid out like the
// BANK=0 map. The block also supplies the next transmit byte for reads and
// drives the two GPIO output latches.
//
// Ports
//   sysClk     system clock, all logic on its rising edge
//   reset      asynchronous, active-high reset
//   cs_active  synchronised chip select, 1 = frame in progress
//   rx_valid   one-cycle strobe, rx_byte holds a complete received byte
//   rx_byte    received byte
//   tx_byte    byte the SPI slave transmits on the next transfer
//   tx_load    one-cycle strobe, tx_byte was updated and must be reloaded
//   busy       1 whenever the frame FSM is not IDLE
//   op_err     one-cycle pulse, opcode byte did not address this device
//   gpio_a     OLATA register (0x14)
//   gpio_b     OLATB register (0x15)
//   dbg_addr   debug read address
//   dbg_data   combinational bank[dbg_addr], 0x00 when out of range
// -----------------------------------------------------------------------------
module mcp_reg_decoder #(
   parameter logic [2:0] DEV_ADDR = 3'b000,
   parameter int          NUM_REGS = 22
) (
   input  logic       sysClk,
   input  logic       reset,
   input  logic       cs_active,
   input  logic       rx_valid,
   input  logic [7:0] rx_byte,
   output logic [7:0] tx_byte,
   output logic       tx_load,
   output logic       busy,
   output logic       op_err,
   output logic [7:0] gpio_a,
   output logic [7:0] gpio_b,
   input  logic [4:0] dbg_addr,
   output logic [7:0] dbg_data
);

   typedef enum logic [2:0] {
      IDLE,
      OPCODE,
      ADDR,
      WRITE,
      READ,
      IGNORE
   } state_t;

   localparam logic [5:0] NUM_REGS_W = 6'(NUM_REGS);
   localparam logic [4:0] LAST_ADDR  = 5'(NUM_REGS - 1);
   localparam logic [4:0] IOCON_A    = 5'h0A;
   localparam logic [4:0] IOCON_B    = 5'h0B;
   localparam logic [4:0] OLAT_A     = 5'h14;
   localparam logic [4:0] OLAT_B     = 5'h15;

   state_t     state;
   state_t     next_state;
   logic [4:0] ptr;
   logic       rw;
   logic [7:0] bank [NUM_REGS];

   logic       byte_take;
   logic       opcode_ok;
   logic       seqop;
   logic [4:0] ptr_adv;
   logic [4:0] rx_addr;
   logic       rx_addr_ok;
   logic       ptr_ok;
   logic       ptr_adv_ok;
   logic       dbg_ok;
   logic [7:0] rx_addr_data;
   logic [7:0] ptr_adv_data;
   logic       tx_load_d;
   logic       op_err_d;

   // A byte only counts while the frame is still open. A strobe that lands in
   // the same cycle chip select drops belongs to no frame and is dropped.
   assign byte_take = rx_valid & cs_active;

   // The opcode must read 0100_AAA_x with AAA equal to this device's address.
   assign opcode_ok = (rx_byte[7:4] == 4'h4) && (rx_byte[3:1] == DEV_ADDR);

   // SEQOP lives in IOCON bit 5. When it is set the pointer stays put, so
   // repeated bytes go to one register.
   assign seqop = bank[IOCON_A][5];

   // The pointer wraps at the last real register rather than at 31, so a
   // sequential burst cycles through the 22-entry map only.
   always_comb begin
      ptr_adv = ptr;
      if (!seqop) begin
         if (ptr == LAST_ADDR) begin
            ptr_adv = 5'd0;
         end else begin
            ptr_adv = ptr + 5'd1;
         end
      end
   end

   // Address range checks. Holes above the map read as zero and swallow
   // writes.
   assign rx_addr    = rx_byte[4:0];
   assign rx_addr_ok = ({1'b0, rx_addr}  < NUM_REGS_W);
   assign ptr_ok     = ({1'b0, ptr}      < NUM_REGS_W);
   assign ptr_adv_ok = ({1'b0, ptr_adv}  < NUM_REGS_W);
   assign dbg_ok     = ({1'b0, dbg_addr} < NUM_REGS_W);

   // Register read ports: the addressed register for the first read byte, the
   // register after the pointer advance for follow-on read bytes, and the
   // debug port.
   always_comb begin
      rx_addr_data = 8'h00;
      ptr_adv_data = 8'h00;
      dbg_data     = 8'h00;
      if (rx_addr_ok) begin
         rx_addr_data = bank[rx_addr];
      end
      if (ptr_adv_ok) begin
         ptr_adv_data = bank[ptr_adv];
      end
      if (dbg_ok) begin
         dbg_data = bank[dbg_addr];
      end
   end

   // Frame state register.
   always_ff @(posedge sysClk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state and strobe decode. Dropping chip select always wins and
   // returns to IDLE, so a half-decoded frame leaves nothing behind. The two
   // strobes are decoded here and registered so they appear one cycle after
   // the byte, together with the data they describe.
   always_comb begin
      next_state = state;
      tx_load_d  = 1'b0;
      op_err_d   = 1'b0;
      if (state == IDLE) begin
         if (cs_active) begin
            next_state = OPCODE;
         end
      end else if (!cs_active) begin
         next_state = IDLE;
      end else if (rx_valid) begin
         case (state)
            OPCODE: begin
               if (opcode_ok) begin
                  next_state = ADDR;
               end else begin
                  next_state = IGNORE;
                  op_err_d   = 1'b1;
               end
            end
            ADDR: begin
               if (rw) begin
                  next_state = READ;
                  tx_load_d  = 1'b1;
               end else begin
                  next_state = WRITE;
               end
            end
            READ: begin
               tx_load_d = 1'b1;
            end
            default: begin
               next_state = state;
            end
         endcase
      end
   end

   // Datapath: pointer, direction, transmit byte and the register bank.
   // IODIRA/B come out of reset as all-inputs (0xFF), matching the part.
   // Writing either IOCON address updates both copies, because the device
   // exposes one physical IOCON at two addresses.
   always_ff @(posedge sysClk or posedge reset) begin
      if (reset) begin
         ptr     <= 5'd0;
         rw      <= 1'b0;
         tx_byte <= 8'h00;
         tx_load <= 1'b0;
         op_err  <= 1'b0;
         for (int i = 0; i < NUM_REGS; i++) begin
            bank[i] <= (i < 2) ? 8'hFF : 8'h00;
         end
      end else begin
         tx_load <= tx_load_d;
         op_err  <= op_err_d;
         if (byte_take) begin
            case (state)
               OPCODE: begin
                  if (opcode_ok) begin
                     rw <= rx_byte[0];
                  end
               end
               ADDR: begin
                  ptr <= rx_addr;
                  if (rw) begin
                     tx_byte <= rx_addr_data;
                  end
               end
               WRITE: begin
                  if (ptr_ok) begin
                     if ((ptr == IOCON_A) || (ptr == IOCON_B)) begin
                        bank[IOCON_A] <= rx_byte;
                        bank[IOCON_B] <= rx_byte;
                     end else begin
                        bank[ptr] <= rx_byte;
                     end
                  end
                  ptr <= ptr_adv;
               end
               READ: begin
                  ptr     <= ptr_adv;
                  tx_byte <= ptr_adv_data;
               end
               default: begin
                  ptr <= ptr;
               end
            endcase
         end
      end
   end

   // Board-facing outputs.
   assign busy   = (state != IDLE);
   assign gpio_a = bank[OLAT_A];
   assign gpio_b = bank[OLAT_B];

endmodule

// File: tb/tb_mcp_reg_decoder.sv
// -----------------------------------------------------------------------------
// tb_mcp_reg_decoder
//
// Directed bench for mcp_reg_decoder. Each task drives one scenario and checks
// its own results against hand-computed values. Inputs change on the falling
// edge and outputs are sampled on the falling edge, away from the active edge.
// -----------------------------------------------------------------------------
module tb_mcp_reg_decoder;

   logic       sysClk;
   logic       reset;
   logic       cs_active;
   logic       rx_valid;
   logic [7:0] rx_byte;
   logic [7:0] tx_byte;
   logic       tx_load;
   logic       busy;
   logic       op_err;
   logic [7:0] gpio_a;
   logic [7:0] gpio_b;
   logic [4:0] dbg_addr;
   logic [7:0] dbg_data;

   int checks;
   int fails;

   mcp_reg_decoder #(
      .DEV_ADDR (3'b000),
      .NUM_REGS (22)
   ) dut (
      .sysClk    (sysClk),
      .reset     (reset),
      .cs_active (cs_active),
      .rx_valid  (rx_valid),
      .rx_byte   (rx_byte),
      .tx_byte   (tx_byte),
      .tx_load   (tx_load),
      .busy      (busy),
      .op_err    (op_err),
      .gpio_a    (gpio_a),
      .gpio_b    (gpio_b),
      .dbg_addr  (dbg_addr),
      .dbg_data  (dbg_data)
   );

   // Free-running 10-unit clock.
   initial begin
      sysClk = 1'b0;
      forever #5 sysClk = ~sysClk;
   end

   // Open a frame. One cycle later the decoder sits in OPCODE.
   task automatic start_frame();
      @(negedge sysClk);
      cs_active = 1'b1;
      @(negedge sysClk);
   endtask

   // Present one byte for one cycle. On return the update from that byte is
   // visible.
   task automatic send_byte(input logic [7:0] b);
      rx_valid = 1'b1;
      rx_byte  = b;
      @(negedge sysClk);
      rx_valid = 1'b0;
   endtask

   // Close the frame and let the decoder settle back in IDLE.
   task automatic end_frame();
      cs_active = 1'b0;
      @(negedge sysClk);
      @(negedge sysClk);
   endtask

   task automatic test_reset();
      reset     = 1'b1;
      cs_active = 1'b0;
      rx_valid  = 1'b0;
      rx_byte   = 8'h00;
      dbg_addr  = 5'h00;
      repeat (3) @(negedge sysClk);
      reset = 1'b0;
      @(negedge sysClk);
      dbg_addr = 5'h00;
      #1;
      checks++;
      if (dbg_data !== 8'hFF) begin
         fails++;
         $display("[TB] FAIL reset_iodira: got %h expected %h", dbg_data, 8'hFF);
      end
      dbg_addr = 5'h01;
      #1;
      checks++;
      if (dbg_data !== 8'hFF) begin
         fails++;
         $display("[TB] FAIL reset_iodirb: got %h expected %h", dbg_data, 8'hFF);
      end
      dbg_addr = 5'h0A;
      #1;
      checks++;
      if (dbg_data !== 8'h00) begin
         fails++;
         $display("[TB] FAIL reset_iocon: got %h expected %h", dbg_data, 8'h00);
      end
      dbg_addr = 5'h14;
      #1;
      checks++;
      if (dbg_data !== 8'h00) begin
         fails++;
         $display("[TB] FAIL reset_olata: got %h expected %h", dbg_data, 8'h00);
      end
      checks++;
      if (tx_byte !== 8'h00) begin
         fails++;
         $display("[TB] FAIL reset_tx_byte: got %h expected %h", tx_byte, 8'h00);
      end
      checks++;
      if ({busy, tx_load, op_err} !== 3'b000) begin
         fails++;
         $display("[TB] FAIL reset_flags: got %b expected %b", {busy, tx_load, op_err}, 3'b000);
      end
   endtask

   task automatic test_olat_write();
      start_frame();
      checks++;
      if (busy !== 1'b1) begin
         fails++;
         $display("[TB] FAIL olat_busy: got %b expected %b", busy, 1'b1);
      end
      send_byte(8'h40);
      send_byte(8'h14);
      send_byte(8'hA5);
      checks++;
      if (gpio_a !== 8'hA5) begin
         fails++;
         $display("[TB] FAIL olat_gpio_a: got %h expected %h", gpio_a, 8'hA5);
      end
      send_byte(8'h3C);
      checks++;
      if (gpio_b !== 8'h3C) begin
         fails++;
         $display("[TB] FAIL olat_gpio_b: got %h expected %h", gpio_b, 8'h3C);
      end
      end_frame();
      checks++;
      if (busy !== 1'b0) begin
         fails++;
         $display("[TB] FAIL olat_idle: got %b expected %b", busy, 1'b0);
      end
   endtask

   task automatic test_iocon_mirror();
      start_frame();
      send_byte(8'h40);
      send_byte(8'h0A);
      send_byte(8'h28);
      end_frame();
      dbg_addr = 5'h0B;
      #1;
      checks++;
      if (dbg_data !== 8'h28) begin
         fails++;
         $display("[TB] FAIL mirror_0b: got %h expected %h", dbg_data, 8'h28);
      end
      start_frame();
      send_byte(8'h41);
      checks++;
      if (tx_load !== 1'b0) begin
         fails++;
         $display("[TB] FAIL mirror_no_load_op: got %b expected %b", tx_load, 1'b0);
      end
      send_byte(8'h0A);
      checks++;
      if ({tx_load, tx_byte} !== {1'b1, 8'h28}) begin
         fails++;
         $display("[TB] FAIL mirror_addr_load: got %b/%h expected 1/28", tx_load, tx_byte);
      end
      @(negedge sysClk);
      checks++;
      if (tx_load !== 1'b0) begin
         fails++;
         $display("[TB] FAIL mirror_load_pulse: got %b expected %b", tx_load, 1'b0);
      end
      send_byte(8'h00);
      checks++;
      if ({tx_load, tx_byte} !== {1'b1, 8'h28}) begin
         fails++;
         $display("[TB] FAIL mirror_dummy_load: got %b/%h expected 1/28", tx_load, tx_byte);
      end
      end_frame();
   endtask

   task automatic test_seqop_hold();
      start_frame();
      send_byte(8'h40);
      send_byte(8'h0A);
      send_byte(8'h20);
      end_frame();
      start_frame();
      send_byte(8'h40);
      send_byte(8'h00);
      send_byte(8'h11);
      send_byte(8'h22);
      end_frame();
      dbg_addr = 5'h00;
      #1;
      checks++;
      if (dbg_data !== 8'h22) begin
         fails++;
         $display("[TB] FAIL seqop_reg0: got %h expected %h", dbg_data, 8'h22);
      end
      dbg_addr = 5'h01;
      #1;
      checks++;
      if (dbg_data !== 8'hFF) begin
         fails++;
         $display("[TB] FAIL seqop_reg1: got %h expected %h", dbg_data, 8'hFF);
      end
   endtask

   task automatic test_op_err();
      start_frame();
      send_byte(8'h42);
      checks++;
      if (op_err !== 1'b1) begin
         fails++;
         $display("[TB] FAIL operr_pulse: got %b expected %b", op_err, 1'b1);
      end
      @(negedge sysClk);
      checks++;
      if (op_err !== 1'b0) begin
         fails++;
         $display("[TB] FAIL operr_width: got %b expected %b", op_err, 1'b0);
      end
      send_byte(8'h14);
      send_byte(8'h77);
      end_frame();
      checks++;
      if (gpio_a !== 8'hA5) begin
         fails++;
         $display("[TB] FAIL operr_ignored: got %h expected %h", gpio_a, 8'hA5);
      end
      start_frame();
      send_byte(8'h40);
      checks++;
      if (op_err !== 1'b0) begin
         fails++;
         $display("[TB] FAIL operr_good_op: got %b expected %b", op_err, 1'b0);
      end
      send_byte(8'h14);
      send_byte(8'h77);
      end_frame();
      checks++;
      if (gpio_a !== 8'h77) begin
         fails++;
         $display("[TB] FAIL operr_recover: got %h expected %h", gpio_a, 8'h77);
      end
   endtask

   task automatic test_wrap();
      start_frame();
      send_byte(8'h40);
      send_byte(8'h0A);
      send_byte(8'h00);
      end_frame();
      start_frame();
      send_byte(8'h40);
      send_byte(8'h15);
      send_byte(8'hAA);
      send_byte(8'hBB);
      cs_active = 1'b0;
      rx_valid  = 1'b1;
      rx_byte   = 8'h99;
      @(negedge sysClk);
      rx_valid = 1'b0;
      checks++;
      if (tx_load !== 1'b0) begin
         fails++;
         $display("[TB] FAIL wrap_late_load: got %b expected %b", tx_load, 1'b0);
      end
      @(negedge sysClk);
      checks++;
      if (gpio_b !== 8'hAA) begin
         fails++;
         $display("[TB] FAIL wrap_reg15: got %h expected %h", gpio_b, 8'hAA);
      end
      dbg_addr = 5'h00;
      #1;
      checks++;
      if (dbg_data !== 8'hBB) begin
         fails++;
         $display("[TB] FAIL wrap_reg0: got %h expected %h", dbg_data, 8'hBB);
      end
      dbg_addr = 5'h01;
      #1;
      checks++;
      if (dbg_data !== 8'hFF) begin
         fails++;
         $display("[TB] FAIL wrap_late_write: got %h expected %h", dbg_data, 8'hFF);
      end
   endtask

   task automatic test_read_range();
      start_frame();
      send_byte(8'h41);
      send_byte(8'h1F);
      checks++;
      if ({tx_load, tx_byte} !== {1'b1, 8'h00}) begin
         fails++;
         $display("[TB] FAIL read_oob: got %b/%h expected 1/00", tx_load, tx_byte);
      end
      end_frame();
      start_frame();
      send_byte(8'h41);
      send_byte(8'h15);
      checks++;
      if (tx_byte !== 8'hAA) begin
         fails++;
         $display("[TB] FAIL read_reg15: got %h expected %h", tx_byte, 8'hAA);
      end
      send_byte(8'h00);
      checks++;
      if ({tx_load, tx_byte} !== {1'b1, 8'hBB}) begin
         fails++;
         $display("[TB] FAIL read_wrap: got %b/%h expected 1/BB", tx_load, tx_byte);
      end
      end_frame();
      dbg_addr = 5'h1F;
      #1;
      checks++;
      if (dbg_data !== 8'h00) begin
         fails++;
         $display("[TB] FAIL dbg_oob: got %h expected %h", dbg_data, 8'h00);
      end
   endtask

   task automatic test_reset_midframe();
      start_frame();
      send_byte(8'h40);
      send_byte(8'h14);
      #1;
      reset = 1'b1;
      #1;
      checks++;
      if ({busy, gpio_a, tx_byte} !== {1'b0, 8'h00, 8'h00}) begin
         fails++;
         $display("[TB] FAIL midreset_state: got %b/%h/%h expected 0/00/00", busy, gpio_a, tx_byte);
      end
      dbg_addr = 5'h00;
      #1;
      checks++;
      if (dbg_data !== 8'hFF) begin
         fails++;
         $display("[TB] FAIL midreset_bank: got %h expected %h", dbg_data, 8'hFF);
      end
      cs_active = 1'b0;
      @(negedge sysClk);
      reset = 1'b0;
      @(negedge sysClk);
   endtask

   // Scenario sequence. Later tasks rely on register contents left by earlier
   // ones (gpio_a=A5 before the opcode-error test, SEQOP state, and so on).
   initial begin
      checks = 0;
      fails  = 0;
      test_reset();
      test_olat_write();
      test_iocon_mirror();
      test_seqop_hold();
      test_op_err();
      test_wrap();
      test_read_range();
      test_reset_midframe();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, fails);
      $finish;
   end

endmodule
